// File: rtl/line_buf_ctrl.sv
// Two-bank line buffer controller: writes incoming lines into alternating RAM
// banks, reads the previous rows back in lock-step, then flushes the final row.
module line_buf_ctrl #(
  parameter int H_ACT     = 1920,
  parameter int V_ACT     = 1080,
  parameter int FLUSH_GAP = 280,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_in,
  input  logic              de_in,
  output logic              wr_en_0,
  output logic              wr_en_1,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              ctr_sel,
  output logic              rd_valid,
  output logic              first_row,
  output logic              last_row,
  output logic              first_col,
  output logic              last_col,
  output logic              frame_done,
  output logic              err_len,
  output logic              err_frm,
  output logic              busy
);

  localparam int CW = ADDR_W + 1;
  localparam int LW = $clog2(V_ACT + 1) + 1;
  localparam int GW = $clog2(FLUSH_GAP + 1) + 1;

  localparam logic [CW-1:0]     H_LEN     = CW'(H_ACT);
  localparam logic [CW-1:0]     H_OVR     = CW'(H_ACT + 1);
  localparam logic [LW-1:0]     LAST_LINE = LW'(V_ACT - 1);
  localparam logic [GW-1:0]     GAP_END   = GW'(FLUSH_GAP - 1);
  localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(H_ACT - 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, GAP, FLUSH} state_t;

  state_t          state, state_nx;
  logic            vs_q, de_q;
  logic [CW-1:0]   pix;       // de beats seen this line, saturates at H_ACT+1
  logic [LW-1:0]   in_line;
  logic [GW-1:0]   gap_cnt;
  logic [CW-1:0]   fcnt;
  logic            vs_rise, vs_fall, de_rise, de_fall;
  logic            line_st, beat, flush_rd;

  assign vs_rise  = vs_in & ~vs_q;
  assign vs_fall  = ~vs_in & vs_q;
  assign de_rise  = de_in & ~de_q;
  assign de_fall  = ~de_in & de_q;
  assign line_st  = (state == FILL) || (state == RUN);
  assign beat     = line_st & de_in & ~vs_fall & (pix < H_LEN);
  assign flush_rd = (state == FLUSH) && (fcnt < H_LEN);

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (vs_rise) state_nx = FILL;
      FILL: begin
        if (vs_fall)      state_nx = IDLE;
        else if (de_fall) state_nx = RUN;
      end
      RUN: begin
        if (vs_fall)                                state_nx = IDLE;
        else if (de_fall && in_line == LAST_LINE)   state_nx = GAP;
      end
      GAP:   if (gap_cnt == GAP_END) state_nx = FLUSH;
      FLUSH: begin
        // two tail cycles: one for rd_valid's last beat, one for the pulse
        if (fcnt == H_OVR) begin
          frame_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read side mirrors the write side during RUN (read-first RAM gives the up row)
  assign busy      = (state != IDLE);
  assign first_row = (state == RUN) && (in_line == LW'(1));
  assign last_row  = (state == FLUSH);
  assign rd_en     = ((state == RUN) && (wr_en_0 || wr_en_1)) || flush_rd;
  assign rd_addr   = (state == FLUSH) ? (flush_rd ? fcnt[ADDR_W-1:0] : '0)
                   : (state == RUN)   ? wr_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      pix       <= '0;
      in_line   <= '0;
      gap_cnt   <= '0;
      fcnt      <= '0;
      wr_en_0   <= 1'b0;
      wr_en_1   <= 1'b0;
      wr_addr   <= '0;
      rd_valid  <= 1'b0;
      first_col <= 1'b0;
      last_col  <= 1'b0;
      ctr_sel   <= 1'b0;
      err_len   <= 1'b0;
      err_frm   <= 1'b0;
    end else begin
      state     <= state_nx;
      vs_q      <= vs_in;
      de_q      <= de_in;
      pix       <= (line_st && de_in) ? ((pix == H_OVR) ? pix : pix + 1'b1) : '0;
      wr_en_0   <= beat & ~in_line[0];
      wr_en_1   <= beat & in_line[0];
      wr_addr   <= (line_st && de_in && !vs_fall) ? (beat ? pix[ADDR_W-1:0] : A_LAST) : '0;
      rd_valid  <= rd_en;
      first_col <= rd_en && (rd_addr == '0);
      last_col  <= rd_en && (rd_addr == A_LAST);
      gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      fcnt      <= (state == FLUSH) ? fcnt + 1'b1 : '0;

      if (state == IDLE && vs_rise) begin
        in_line <= '0;
        err_len <= 1'b0;
        err_frm <= 1'b0;
      end else begin
        if (vs_rise) err_frm <= 1'b1;
        if (line_st && vs_fall) err_frm <= 1'b1;
        if ((state == GAP || state == FLUSH) && de_rise) err_frm <= 1'b1;
        if (line_st && de_fall && !vs_fall) begin
          in_line <= in_line + 1'b1;
          if (pix != H_LEN) err_len <= 1'b1;
          // next line k=in_line+1 uses bank (k-1)[0] as centre
          if (state == RUN) ctr_sel <= in_line[0];
        end
      end
      if (state_nx == IDLE) ctr_sel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Scoreboard bench for line_buf_ctrl: expected write/read beats are queued as
// lines are driven and popped as the controller emits them.
module tb_line_buf_ctrl;
  localparam int H = 8, V = 4, G = 3, AW = 4;

  logic clk = 1'b0, rst = 1'b1, vs_in = 1'b0, de_in = 1'b0;
  logic wr_en_0, wr_en_1, rd_en, ctr_sel, rd_valid, first_row, last_row;
  logic first_col, last_col, frame_done, err_len, err_frm, busy;
  logic [AW-1:0] wr_addr, rd_addr;

  line_buf_ctrl #(.H_ACT(H), .V_ACT(V), .FLUSH_GAP(G), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in),
    .wr_en_0(wr_en_0), .wr_en_1(wr_en_1), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .ctr_sel(ctr_sel), .rd_valid(rd_valid),
    .first_row(first_row), .last_row(last_row), .first_col(first_col),
    .last_col(last_col), .frame_done(frame_done), .err_len(err_len),
    .err_frm(err_frm), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] addr; logic ctr; logic fr; logic lr;} rd_t;
  typedef struct packed {logic bank; logic [AW-1:0] addr;} wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  checks = 0, passed = 0, fails = 0, fd_seen = 0, fd_cd = 0;
  logic prev_rd = 1'b0;
  rd_t prev_exp = '0, mon_r;
  wr_t mon_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0;
      fd_cd   = 0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_cd == 1));
      if (fd_cd > 0) fd_cd--;
      if (frame_done) fd_seen++;
      chk("rd_valid", 32'(rd_valid), 32'(prev_rd));
      if (prev_rd) begin
        chk("first_col", 32'(first_col), 32'(prev_exp.addr == 0));
        chk("last_col", 32'(last_col), 32'(prev_exp.addr == AW'(H - 1)));
      end
      prev_rd = 1'b0;
      if (wr_en_0 || wr_en_1) begin
        chk("wr_onehot", 32'(wr_en_0 & wr_en_1), 32'(0));
        if (wr_q.size() == 0) chk("wr_unexpected", 32'(wr_en_0 | wr_en_1), 32'(0));
        else begin
          mon_w = wr_q.pop_front();
          chk("wr_bank", 32'(wr_en_1), 32'(mon_w.bank));
          chk("wr_addr", 32'(wr_addr), 32'(mon_w.addr));
        end
      end
      if (rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_en), 32'(0));
        else begin
          mon_r = rd_q.pop_front();
          chk("rd_addr", 32'(rd_addr), 32'(mon_r.addr));
          chk("ctr_sel", 32'(ctr_sel), 32'(mon_r.ctr));
          chk("first_row", 32'(first_row), 32'(mon_r.fr));
          chk("last_row", 32'(last_row), 32'(mon_r.lr));
          prev_exp = mon_r;
          if (mon_r.lr && mon_r.addr == AW'(H - 1)) fd_cd = 2;
        end
        prev_rd = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int i, input int len);
    wr_t w;
    rd_t r;
    if (i < V) begin
      for (int j = 0; j < len && j < H; j++) begin
        w.bank = 1'(i % 2);
        w.addr = AW'(j);
        wr_q.push_back(w);
        if (i >= 1) begin
          r.addr = AW'(j);
          r.ctr  = 1'((i - 1) % 2);
          r.fr   = (i == 1);
          r.lr   = 1'b0;
          rd_q.push_back(r);
        end
      end
    end
    de_in = 1'b1;
    for (int j = 0; j < len; j++) begin
      tick();
      if (j >= H) begin
        chk("long_addr_hold", 32'(wr_addr), 32'(H - 1));
        chk("long_no_beat", 32'({wr_en_0, wr_en_1, rd_en}), 32'(0));
      end
    end
    de_in = 1'b0;
  endtask

  task automatic push_flush();
    rd_t r;
    for (int j = 0; j < H; j++) begin
      r.addr = AW'(j);
      r.ctr  = 1'((V - 1) % 2);
      r.fr   = 1'b0;
      r.lr   = 1'b1;
      rd_q.push_back(r);
    end
  endtask

  task automatic run_frame(input int nlines, input int long_idx, input int abort_after,
                           input bit rst_flush, input bit exp_len, input bit exp_frm);
    int fd0, n;
    bit hit;
    fd0 = fd_seen;
    vs_in = 1'b1;
    tick();
    tick();
    chk("start_busy", 32'(busy), 32'(1));
    chk("start_err_clear", 32'({err_len, err_frm}), 32'(0));
    for (int i = 0; i < nlines; i++) begin
      drive_line(i, (i == long_idx) ? H + 2 : H);
      if (i == V - 1) push_flush();
      if (i == abort_after) begin
        vs_in = 1'b0;
        tick();
        chk("abort_idle", 32'(busy), 32'(0));
        break;
      end
      repeat (2) tick();
    end
    vs_in = 1'b0;
    if (rst_flush) begin
      hit = 1'b0;
      for (int k = 0; k < 60 && !hit; k++) begin
        tick();
        if (rd_en && last_row && rd_addr == AW'(4)) hit = 1'b1;
      end
      chk("flush_reached", 32'(hit), 32'(1));
      rst = 1'b1;
      tick();
      chk("reset_outputs", 32'({wr_en_0, wr_en_1, wr_addr, rd_en, rd_addr, ctr_sel, rd_valid,
          first_row, last_row, first_col, last_col, frame_done, err_len, err_frm, busy}), 32'(0));
      rst = 1'b0;
      rd_q.delete();
      wr_q.delete();
      repeat (3) tick();
      chk("reset_no_done", 32'(fd_seen - fd0), 32'(0));
    end else begin
      n = 0;
      while (busy && n < 200) begin
        tick();
        n++;
      end
      chk("done_timeout", 32'(busy), 32'(0));
      repeat (3) tick();
      chk("done_count", 32'(fd_seen - fd0), 32'((abort_after >= 0) ? 0 : 1));
      chk("err_len", 32'(err_len), 32'(exp_len));
      chk("err_frm", 32'(err_frm), 32'(exp_frm));
      chk("wr_q_left", 32'(wr_q.size()), 32'(0));
      chk("rd_q_left", 32'(rd_q.size()), 32'(0));
    end
  endtask

  initial begin
    rst   = 1'b1;
    vs_in = 1'b1;  // vs already high at release must still start a frame
    repeat (3) tick();
    chk("reset_state", 32'({wr_en_0, wr_en_1, wr_addr, rd_en, rd_addr, ctr_sel, rd_valid,
        first_row, last_row, first_col, last_col, frame_done, err_len, err_frm, busy}), 32'(0));
    rst = 1'b0;
    run_frame(4, -1, -1, 1'b0, 1'b0, 1'b0);  // nominal
    run_frame(4,  2, -1, 1'b0, 1'b1, 1'b0);  // line 2 too long
    run_frame(4, -1,  1, 1'b0, 1'b0, 1'b1);  // vs drops after line 1
    run_frame(4, -1, -1, 1'b0, 1'b0, 1'b0);  // recovers clean
    run_frame(4, -1, -1, 1'b1, 1'b0, 1'b0);  // reset mid-flush
    run_frame(4, -1, -1, 1'b0, 1'b0, 1'b0);  // nominal after reset
    run_frame(5, -1, -1, 1'b0, 1'b0, 1'b1);  // one extra line
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
